// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bundle between the 5-stage pipeline datapath (master) and hazard_ctrl (slave).
interface hazard_ctrl_if #(parameter int CNT_W = 32);
   logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic             ResultSrcE0, RegWriteM, RegWriteW, PCSrcE;
   logic             MemReqM, dmem_ready, clr_cnt;
   logic [1:0]       ForwardAE, ForwardBE;
   logic             StallF, StallD, StallE, StallM;
   logic             FlushD, FlushE, FlushW;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output ResultSrcE0, RegWriteM, RegWriteW, PCSrcE,
      output MemReqM, dmem_ready, clr_cnt,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
      input  FlushD, FlushE, FlushW, mem_err, stall_cnt, flush_cnt
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  ResultSrcE0, RegWriteM, RegWriteW, PCSrcE,
      input  MemReqM, dmem_ready, clr_cnt,
      output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
      output FlushD, FlushE, FlushW, mem_err, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding, load-use / branch / data-memory-wait stall+flush,
// memory timeout FSM with sticky error, and saturating stall/flush counters.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   hazard_ctrl_if.slave hz
);
   localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

   state_t            state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              mem_err_q, mem_err_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   logic mem_stall, lw_stall;
   logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;

   // MEM stage has priority: it holds the younger (more recent) write.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m,
                                          input logic [4:0] rd_m, input logic wr_w,
                                          input logic [4:0] rd_w);
      if (wr_m && rd_m != 5'd0 && rd_m == rs)      fwd_sel = 2'b10;
      else if (wr_w && rd_w != 5'd0 && rd_w == rs) fwd_sel = 2'b01;
      else                                         fwd_sel = 2'b00;
   endfunction

   assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
   assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);

   assign lw_stall  = hz.ResultSrcE0 && hz.RdE != 5'd0 &&
                      (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D) && !hz.PCSrcE;
   assign mem_stall = (state_q == ERR) ||
                      ((state_q == WAIT || state_q == IDLE) && hz.MemReqM && !hz.dmem_ready);

   // A branch seen during a memory stall is deferred: EX is frozen, so PCSrcE survives.
   always_comb begin
      stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
      flush_d = 1'b0; flush_e = 1'b0; flush_w = 1'b0;
      if (mem_stall) begin
         stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (hz.PCSrcE) begin
         flush_d = 1'b1; flush_e = 1'b1;
      end else if (lw_stall) begin
         stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
      end
   end

   assign hz.StallF = stall_f;
   assign hz.StallD = stall_d;
   assign hz.StallE = stall_e;
   assign hz.StallM = stall_m;
   assign hz.FlushD = flush_d;
   assign hz.FlushE = flush_e;
   assign hz.FlushW = flush_w;

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      mem_err_d = mem_err_q;
      case (state_q)
         IDLE: begin
            if (hz.MemReqM && !hz.dmem_ready) begin
               state_d = WAIT;
               wcnt_d  = WCNT_W'(1);
            end
         end
         WAIT: begin
            if (hz.dmem_ready || !hz.MemReqM) begin
               state_d = IDLE;
               wcnt_d  = '0;
            end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT - 1)) begin
               state_d   = ERR;
               mem_err_d = 1'b1;
            end else begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end
         end
         ERR:     mem_err_d = 1'b1;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (hz.clr_cnt) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall_f && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (hz.PCSrcE && !mem_stall && flush_cnt_q != {CNT_W{1'b1}})
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         wcnt_q      <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.mem_err   = mem_err_q;
   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second CNT_W=4 instance mirrors the stimulus for saturation.
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic reset_n;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(32)) hm ();
   hazard_ctrl_if #(.CNT_W(4))  hs ();

   hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) u_dut   (.clk(clk), .reset_n(reset_n), .hz(hm.slave));
   hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4))  u_dut_s (.clk(clk), .reset_n(reset_n), .hz(hs.slave));

   assign hs.Rs1D = hm.Rs1D;   assign hs.Rs2D = hm.Rs2D;
   assign hs.Rs1E = hm.Rs1E;   assign hs.Rs2E = hm.Rs2E;
   assign hs.RdE  = hm.RdE;    assign hs.RdM  = hm.RdM;   assign hs.RdW = hm.RdW;
   assign hs.ResultSrcE0 = hm.ResultSrcE0;
   assign hs.RegWriteM   = hm.RegWriteM;
   assign hs.RegWriteW   = hm.RegWriteW;
   assign hs.PCSrcE      = hm.PCSrcE;
   assign hs.MemReqM     = hm.MemReqM;
   assign hs.dmem_ready  = hm.dmem_ready;
   assign hs.clr_cnt     = hm.clr_cnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      hm.Rs1D = 0; hm.Rs2D = 0; hm.Rs1E = 0; hm.Rs2E = 0;
      hm.RdE = 0; hm.RdM = 0; hm.RdW = 0;
      hm.ResultSrcE0 = 0; hm.RegWriteM = 0; hm.RegWriteW = 0; hm.PCSrcE = 0;
      hm.MemReqM = 0; hm.dmem_ready = 0; hm.clr_cnt = 0;
   endtask

   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
   function automatic logic [6:0] sf();
      return {hm.StallF, hm.StallD, hm.StallE, hm.StallM, hm.FlushD, hm.FlushE, hm.FlushW};
   endfunction

   initial begin
      clr_in();
      reset_n = 1'b0;
      #3;
      chk("rst_sf", sf(), 7'b0);
      chk("rst_err", hm.mem_err, 0);
      chk("rst_scnt", hm.stall_cnt, 0);
      chk("rst_fcnt", hm.flush_cnt, 0);
      tick();
      reset_n = 1'b1;
      #1;

      // forwarding
      hm.RegWriteM = 1; hm.RdM = 5; hm.Rs1E = 5; #1;
      chk("fwdA_mem", hm.ForwardAE, 2'b10);
      hm.RegWriteW = 1; hm.RdW = 5; #1;
      chk("fwdA_mem_prio", hm.ForwardAE, 2'b10);
      hm.RegWriteM = 0; hm.Rs2E = 5; #1;
      chk("fwdA_wb", hm.ForwardAE, 2'b01);
      chk("fwdB_wb", hm.ForwardBE, 2'b01);
      hm.RegWriteM = 1; hm.RdM = 0; hm.Rs1E = 0; #1;
      chk("fwdA_x0", hm.ForwardAE, 2'b00);
      chk("fwdB_wb2", hm.ForwardBE, 2'b01);
      clr_in(); #1;

      // load-use, then load-use shadowed by a taken branch
      hm.ResultSrcE0 = 1; hm.RdE = 6; hm.Rs2D = 6; #1;
      chk("lw_sf", sf(), 7'b1100010);
      tick();
      chk("lw_scnt", hm.stall_cnt, 1);
      hm.PCSrcE = 1; #1;
      chk("br_sf", sf(), 7'b0000110);
      tick();
      chk("br_fcnt", hm.flush_cnt, 1);
      chk("br_scnt", hm.stall_cnt, 1);
      clr_in(); #1;

      // 3-cycle memory wait
      hm.MemReqM = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("mw_sf%0d", i), sf(), 7'b1111001);
         tick();
      end
      hm.dmem_ready = 1; #1;
      chk("mw_done_sf", sf(), 7'b0);
      tick();
      chk("mw_scnt", hm.stall_cnt, 4);
      chk("mw_err", hm.mem_err, 0);

      // abort: request dropped while waiting
      hm.dmem_ready = 0; #1;
      tick();
      hm.MemReqM = 0; #1;
      chk("abort_sf", sf(), 7'b0);
      tick();
      hm.MemReqM = 1; hm.dmem_ready = 1; #1;
      chk("abort_idle_sf", sf(), 7'b0);
      chk("abort_scnt", hm.stall_cnt, 5);

      // timeout
      hm.dmem_ready = 0;
      for (int i = 0; i < 16; i++) begin
         #1;
         if (hm.StallF !== 1'b1 || hm.mem_err !== 1'b0)
            chk($sformatf("to_pre%0d", i), {hm.StallF, hm.mem_err}, 2'b10);
         tick();
      end
      hm.MemReqM = 0; hm.dmem_ready = 1; #1;
      chk("to_err", hm.mem_err, 1);
      chk("to_frozen_sf", sf(), 7'b1111001);
      chk("to_scnt", hm.stall_cnt, 21);
      reset_n = 1'b0; #1;
      chk("to_rst_err", hm.mem_err, 0);
      chk("to_rst_sf", sf(), 7'b0);
      chk("to_rst_scnt", hm.stall_cnt, 0);
      reset_n = 1'b1;
      clr_in(); #1;

      // branch deferred behind memory stall
      hm.MemReqM = 1; hm.PCSrcE = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk($sformatf("def_sf%0d", i), sf(), 7'b1111001);
         tick();
      end
      hm.dmem_ready = 1; #1;
      chk("def_free_sf", sf(), 7'b0000110);
      tick();
      chk("def_fcnt", hm.flush_cnt, 1);
      chk("def_scnt", hm.stall_cnt, 2);
      clr_in(); #1;

      // saturation on the narrow instance, then clear under stall
      hm.ResultSrcE0 = 1; hm.RdE = 7; hm.Rs1D = 7;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_small", hs.stall_cnt, 4'hf);
      chk("sat_main", hm.stall_cnt, 22);
      hm.clr_cnt = 1; #1;
      chk("clr_sf", sf(), 7'b1100010);
      tick();
      chk("clr_small", hs.stall_cnt, 0);
      chk("clr_main", hm.stall_cnt, 0);
      chk("clr_fcnt", hm.flush_cnt, 0);
      hm.clr_cnt = 0;
      tick();
      chk("post_clr_scnt", hm.stall_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule
